// File: rtl/solver_result_arbiter.sv
// solver_result_arbiter
//
// Round-robin arbiter sharing the solver's 32-bit result PIO output register
// among NUM_REQ result producers. One result is accepted per valid/ready
// handshake, written to PIO offset 0 with a single-cycle Avalon-MM write, and
// then the bus is held idle for HOLD_CYCLES so the PIO out_port value can be
// sampled externally before the next result replaces it.
//
// Ports:
//   clk_i            system clock, rising edge
//   reset_i          asynchronous active-high reset
//   req_valid_i      per-requester result valid
//   req_data_i       packed results, requester i in bits [32*i+31:32*i]
//   req_ready_o      one-hot accept strobe (transfer when valid & ready)
//   avm_address_o    PIO register offset, always 0
//   avm_chipselect_o PIO chip select (registered)
//   avm_write_n_o    PIO write strobe, active low (registered)
//   avm_writedata_o  result being written; holds last value between writes
//   busy_o           high while writing or holding
//   last_grant_o     index of the most recently accepted requester
//   write_count_o    number of PIO writes issued, wraps silently

module solver_result_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*32-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [1:0]              avm_address_o,
    output logic                    avm_chipselect_o,
    output logic                    avm_write_n_o,
    output logic [31:0]             avm_writedata_o,
    output logic                    busy_o,
    output logic [IDX_W-1:0]        last_grant_o,
    output logic [CNT_W-1:0]        write_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Hold counter counts down to 0, so it is loaded with HOLD_CYCLES-1.
    localparam logic [7:0] HOLD_LOAD =
        (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);
    // Reset to the last index so the first search starts at requester 0.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic             cs_q, cs_d;
    logic             wn_q, wn_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       hold_q, hold_d;

    logic [31:0]      data_arr [NUM_REQ];
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data_i[32*g +: 32];
    end

    // Search upward from last_grant+1 (mod NUM_REQ); first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((32'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        wn_d    = wn_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        count_d = count_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d = ST_WRITE;
                    wdata_d = data_arr[grant_idx];
                    last_d  = grant_idx;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                end
            end
            ST_WRITE: begin
                cs_d    = 1'b0;
                wn_d    = 1'b1;
                count_d = count_q + 1'b1;
                hold_d  = HOLD_LOAD;
                state_d = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b0;
                wn_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= '0;
            last_q  <= LAST_RST;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

    assign avm_address_o    = 2'd0;
    assign avm_chipselect_o = cs_q;
    assign avm_write_n_o    = wn_q;
    assign avm_writedata_o  = wdata_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign last_grant_o     = last_q;
    assign write_count_o    = count_q;

endmodule

// File: tb/tb_solver_result_arbiter.sv
// Directed bench for solver_result_arbiter. Instance a uses HOLD_CYCLES=3,
// CNT_W=16; instance b uses HOLD_CYCLES=0, CNT_W=4. Inputs are driven and
// outputs sampled around the falling edge.

module tb_solver_result_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, rst_b;
    logic [3:0]   valid_a, valid_b;
    logic [127:0] data_a, data_b;
    logic [3:0]   ready_a, ready_b;
    logic [1:0]   addr_a, addr_b;
    logic         cs_a, cs_b, wn_a, wn_b, busy_a, busy_b;
    logic [31:0]  wd_a, wd_b;
    logic [1:0]   lg_a, lg_b;
    logic [15:0]  wc_a;
    logic [3:0]   wc_b;

    solver_result_arbiter #(
        .NUM_REQ(4), .IDX_W(2), .HOLD_CYCLES(3), .CNT_W(16)
    ) dut_a (
        .clk_i(clk), .reset_i(rst_a), .req_valid_i(valid_a), .req_data_i(data_a),
        .req_ready_o(ready_a), .avm_address_o(addr_a), .avm_chipselect_o(cs_a),
        .avm_write_n_o(wn_a), .avm_writedata_o(wd_a), .busy_o(busy_a),
        .last_grant_o(lg_a), .write_count_o(wc_a)
    );

    solver_result_arbiter #(
        .NUM_REQ(4), .IDX_W(2), .HOLD_CYCLES(0), .CNT_W(4)
    ) dut_b (
        .clk_i(clk), .reset_i(rst_b), .req_valid_i(valid_b), .req_data_i(data_b),
        .req_ready_o(ready_b), .avm_address_o(addr_b), .avm_chipselect_o(cs_b),
        .avm_write_n_o(wn_b), .avm_writedata_o(wd_b), .busy_o(busy_b),
        .last_grant_o(lg_b), .write_count_o(wc_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    initial begin
        int nw;
        int last_t;
        int extra;

        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = '0; valid_b = '0;
        data_a = '0; data_b = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset values
        check_eq("rst_ready", 32'(ready_a), 32'h0);
        check_eq("rst_addr", 32'(addr_a), 32'h0);
        check_eq("rst_cs", 32'(cs_a), 32'h0);
        check_eq("rst_wn", 32'(wn_a), 32'h1);
        check_eq("rst_wdata", wd_a, 32'h0);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        check_eq("rst_last", 32'(lg_a), 32'h3);
        check_eq("rst_count", 32'(wc_a), 32'h0);

        // Single requester 2
        data_a[95:64] = 32'hDEADBEEF;
        valid_a = 4'b0100;
        #1 check_eq("t1_ready", 32'(ready_a), 32'h4);
        @(negedge clk);
        check_eq("t1_cs", 32'(cs_a), 32'h1);
        check_eq("t1_wn", 32'(wn_a), 32'h0);
        check_eq("t1_addr", 32'(addr_a), 32'h0);
        check_eq("t1_wdata", wd_a, 32'hDEADBEEF);
        check_eq("t1_busy_w", 32'(busy_a), 32'h1);
        check_eq("t1_last", 32'(lg_a), 32'h2);
        valid_a = '0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_eq("t1_busy_h", 32'(busy_a), 32'h1);
            check_eq("t1_cs_h", 32'(cs_a), 32'h0);
            if (i == 1) check_eq("t1_count", 32'(wc_a), 32'h1);
        end
        @(negedge clk);
        check_eq("t1_busy_end", 32'(busy_a), 32'h0);
        check_eq("t1_wdata_keep", wd_a, 32'hDEADBEEF);

        // All four continuously valid: order 0,1,2,3,0 spaced 5 cycles
        reset_a();
        for (int i = 0; i < 4; i++) data_a[32*i +: 32] = 32'h10 + 32'(i);
        valid_a = 4'hF;
        nw = 0;
        last_t = 0;
        for (int c = 0; c < 40 && nw < 5; c++) begin
            @(negedge clk);
            if (cs_a) begin
                check_eq("t2_data", wd_a, 32'h10 + 32'(nw % 4));
                if (nw > 0) check_eq("t2_gap", 32'(c - last_t), 32'd5);
                last_t = c;
                nw++;
            end
        end
        check_eq("t2_writes", 32'(nw), 32'd5);
        valid_a = '0;

        // Req 3 pulses valid during HOLD of a req 0 write: never granted
        reset_a();
        data_a[31:0]   = 32'hA0;
        data_a[127:96] = 32'hA3;
        valid_a = 4'b0001;
        #1 check_eq("t4_ready0", 32'(ready_a), 32'h1);
        @(negedge clk);
        check_eq("t4_cs", 32'(cs_a), 32'h1);
        check_eq("t4_wdata", wd_a, 32'hA0);
        valid_a = '0;
        @(negedge clk);
        valid_a = 4'b1000;
        #1 check_eq("t4_ready_h1", 32'(ready_a), 32'h0);
        @(negedge clk);
        check_eq("t4_ready_h2", 32'(ready_a), 32'h0);
        @(negedge clk);
        valid_a = '0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cs_a) extra++;
        end
        check_eq("t4_extra", 32'(extra), 32'h0);
        check_eq("t4_count", 32'(wc_a), 32'h1);
        check_eq("t4_last", 32'(lg_a), 32'h0);

        // Asynchronous reset in the WRITE cycle
        reset_a();
        data_a[95:64] = 32'h55;
        valid_a = 4'b0100;
        @(negedge clk);
        check_eq("t5_wn_before", 32'(wn_a), 32'h0);
        #2 rst_a = 1'b1;
        #1;
        check_eq("t5_wn_drop", 32'(wn_a), 32'h1);
        check_eq("t5_cs_drop", 32'(cs_a), 32'h0);
        check_eq("t5_count", 32'(wc_a), 32'h0);
        check_eq("t5_busy", 32'(busy_a), 32'h0);
        valid_a = '0;
        @(negedge clk);
        rst_a = 1'b0;
        valid_a = 4'b1001;
        #1 check_eq("t5_ready", 32'(ready_a), 32'h1);
        @(negedge clk);
        check_eq("t5_wdata", wd_a, 32'hA0);
        check_eq("t5_last", 32'(lg_a), 32'h0);
        valid_a = '0;

        // HOLD_CYCLES=0, req 1 continuous: accept every 2 cycles, count wraps at 16
        data_b[63:32] = 32'hB1;
        valid_b = 4'b0010;
        for (int i = 0; i <= 34; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check_eq("t3_busy", 32'(busy_b), 32'(i % 2));
            check_eq("t3_cs", 32'(cs_b), 32'(i % 2));
            check_eq("t3_ready", 32'(ready_b), (i % 2 == 1) ? 32'h0 : 32'h2);
            if (i % 2 == 0) check_eq("t6_count", 32'(wc_b), 32'((i / 2) % 16));
        end
        check_eq("t3_wdata", wd_b, 32'hB1);
        valid_b = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
